sample_decimator_capture: RTL and testbench
===========================================

// Module: sample_decimator_capture
// PURPOSE
//  Multi-channel audio capture engine: takes NCH parallel DW-bit unsigned sample streams
//  (e.g. mix_out / filtered_out taps) and decimates each by a runtime factor, in point or
//  boxcar-average mode. Captured frames go into an on-chip FIFO and drain over valid/ready.
//  An armed FSM captures a programmed frame count (or runs continuously), then flushes.
//  Sits between the synth output taps and a host readout or WAV-dump path.
// PARAMETERS
//  NCH    2   number of channels captured per frame
//  DW     8   bits per channel sample (unsigned)
//  DEPTH  16  FIFO depth in frames (power of two, >=2)
// PORTS
//  clk          in   1       system clock (12 MHz in the chip)
//  rst          in   1       asynchronous, active-high reset
//  in_data      in   NCH*DW  channel samples, ch0 in [DW-1:0]
//  in_valid     in   1       sample strobe; tie 1 to sample every clk
//  decim        in   16      strobes per output frame; 0 is treated as 1
//  avg_en       in   1       0 = point sample, 1 = boxcar average
//  avg_shift    in   5       right shift applied to the accumulator in average mode
//  num_frames   in   16      frames per capture; 0 = continuous until stop
//  arm          in   1       start pulse (honoured in IDLE only)
//  stop         in   1       abort pulse (honoured in RUN only)
//  out_data     out  NCH*DW  FIFO head frame
//  out_valid    out  1       FIFO not empty
//  out_ready    in   1       consumer accepts head when out_valid & out_ready
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse on the FLUSH->IDLE transition
//  overflow     out  1       sticky; a frame was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: state=IDLE; out_data=0, out_valid=0, busy=0, done=0, overflow=0; FIFO empty;
//   counters and accumulators cleared.
//  FSM: IDLE -arm-> RUN -(frames_pushed==num_frames!=0 | stop)-> FLUSH -(FIFO empty)-> IDLE.
//  Arm in IDLE: clears overflow, frame counter, strobe counter and accumulators; latches decim,
//   avg_en, avg_shift and num_frames. Config changes during RUN have no effect.
//  RUN: each in_valid strobe increments the strobe counter (wraps at decim_eff=max(decim,1)).
//   Point mode: a channel's frame value is the sample taken on the window's first strobe.
//   Average mode: per-channel acc (DW+16 bits) sums every strobe in the window; frame value is
//   min(acc>>avg_shift, 2^DW-1). Saturation is per channel.
//  On the decim_eff-th strobe, the frame (including that strobe's sample) is pushed on the next
//   clk, and acc restarts with the following strobe. No strobe is lost between windows.
//  Latency: last strobe at cycle t -> FIFO write at t+1 -> out_valid at t+2 (no bypass path).
//  Push while full: if out_ready&out_valid in the same cycle, the push is accepted; otherwise the
//   frame is dropped, overflow is set, and the frame still counts toward num_frames.
//  stop in RUN: the partial window is discarded. stop and the final push in the same cycle: the
//   push completes.
//  arm outside IDLE and stop outside RUN are ignored. arm and done can coincide; arm is honoured.
//  FLUSH: in_valid is ignored. The consumer drains the FIFO; done pulses and busy drops on the
//   same edge.
//  out_data holds its value while out_valid=1 and out_ready=0. It is 0 when the FIFO is empty.
//  rst mid-capture: immediate return to reset state. The FIFO contents are discarded.
// TESTING
//  1. in_valid=1, decim=272, avg_en=0, num_frames=4, ch0 = free-running 8-bit counter ->
//     frames 0,16,32,48 (272 mod 256=16); done after drain.
//  2. avg_en=1, decim=4, avg_shift=2, ch0 held at 200, ch1 at 255 -> every frame {255,200}.
//     With avg_shift=0 -> ch0 saturates to 255.
//  3. decim=1, num_frames=20, out_ready=0 -> 16 frames kept, overflow=1 and busy=1 until the
//     drain; then done, and 16 frames are read.
//  4. decim=0, avg_en=0 -> behaves as decim=1: one frame per strobe, first out_valid 2 cycles
//     after the first strobe.
//  5. num_frames=0, decim=8, stop after 3.5 windows -> exactly 3 frames; partial window dropped;
//     done after drain.
//  6. Assert rst during RUN with 5 frames queued -> next cycle out_valid=0, busy=0,
//     overflow=0; re-arm captures cleanly.

Source files
------------

// File: rtl/sample_decimator_capture_if.sv
// Sample-in / frame-out stream bundle for the decimating capture engine.
// master drives samples and readiness; slave is the capture block.
interface sample_decimator_capture_if #(
    parameter int NCH = 2,
    parameter int DW  = 8
);
    logic [NCH*DW-1:0] in_data;
    logic              in_valid;
    logic [NCH*DW-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/sample_decimator_capture.sv
// NCH-channel point/boxcar decimator with an armed capture FSM
// feeding a frame FIFO that drains over valid/ready.
module sample_decimator_capture #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    sample_decimator_capture_if.slave        bus,
    input  logic [15:0]                      decim,
    input  logic                             avg_en,
    input  logic [4:0]                       avg_shift,
    input  logic [15:0]                      num_frames,
    input  logic                             arm,
    input  logic                             stop,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = DW + 16;
    localparam int FW   = NCH * DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t          r_state, w_next;
    logic [15:0]     r_decim, r_nframes, r_scnt, r_fcnt;
    logic            r_avg;
    logic [4:0]      r_shift;
    logic [ACCW-1:0] r_acc [NCH];
    logic [DW-1:0]   r_pt  [NCH];
    logic [DW-1:0]   w_smp [NCH];
    logic [ACCW-1:0] w_acc [NCH];
    logic [ACCW-1:0] w_sh  [NCH];
    logic [FW-1:0]   w_frame, r_frame;
    logic            r_push, r_ovf, r_done;
    logic [FW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_wp, r_rp;
    logic            w_strobe, w_first, w_last, w_final;
    logic            w_empty, w_full, w_pop, w_wr;

    assign w_strobe = (r_state == S_RUN) && bus.in_valid;
    assign w_first  = (r_scnt == 16'd0);
    assign w_last   = w_strobe && (r_scnt == r_decim - 16'd1);
    assign w_final  = w_last && (r_nframes != 16'd0) &&
                      (r_fcnt + 16'd1 == r_nframes);

    // Frame value as it stands including the current strobe's sample.
    always_comb begin
        w_frame = '0;
        for (int c = 0; c < NCH; c++) begin
            w_smp[c] = bus.in_data[c*DW +: DW];
            w_acc[c] = w_first ? ACCW'(w_smp[c])
                               : r_acc[c] + ACCW'(w_smp[c]);
            w_sh[c]  = w_acc[c] >> r_shift;
            if (!r_avg)
                w_frame[c*DW +: DW] = w_first ? w_smp[c] : r_pt[c];
            else if (|w_sh[c][ACCW-1:DW])
                w_frame[c*DW +: DW] = '1;
            else
                w_frame[c*DW +: DW] = w_sh[c][DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (arm) w_next = S_RUN;
            S_RUN:   if (w_final || stop) w_next = S_FLUSH;
            S_FLUSH: if (w_empty && !r_push) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decim   <= 16'd1;
            r_nframes <= 16'd0;
            r_avg     <= 1'b0;
            r_shift   <= 5'd0;
            r_scnt    <= 16'd0;
            r_fcnt    <= 16'd0;
            r_frame   <= '0;
            r_push    <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= '0;
                r_pt[c]  <= '0;
            end
        end else begin
            r_push <= w_last;
            r_done <= (r_state == S_FLUSH) && (w_next == S_IDLE);
            if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
            if (r_state == S_IDLE && arm) begin
                r_decim   <= (decim == 16'd0) ? 16'd1 : decim;
                r_nframes <= num_frames;
                r_avg     <= avg_en;
                r_shift   <= avg_shift;
                r_scnt    <= 16'd0;
                r_fcnt    <= 16'd0;
                r_ovf     <= 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    r_acc[c] <= '0;
                    r_pt[c]  <= '0;
                end
            end else if (w_strobe) begin
                r_scnt <= w_last ? 16'd0 : r_scnt + 16'd1;
                if (w_last) begin
                    r_frame <= w_frame;
                    r_fcnt  <= r_fcnt + 16'd1;
                end
                for (int c = 0; c < NCH; c++) begin
                    r_acc[c] <= w_acc[c];
                    if (w_first) r_pt[c] <= w_smp[c];
                end
            end
        end
    end

    // A push into a full FIFO survives only if the head leaves on the same edge.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= r_frame;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr)  r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign overflow      = r_ovf;
endmodule

// File: tb/tb_sample_decimator_capture.sv
// Directed bench for sample_decimator_capture: point and boxcar
// modes, decim edge values, overflow, stop, and mid-capture reset.
module tb_sample_decimator_capture;
    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] decim, num_frames;
    logic        avg_en;
    logic [4:0]  avg_shift;
    logic        arm, stop;
    logic        busy, done, overflow;

    int          n_tot = 0;
    int          n_bad = 0;
    logic [15:0] got[$];
    int          base;
    logic [7:0]  avg_c0 [4];

    sample_decimator_capture_if #(.NCH(NCH), .DW(DW)) bus ();

    sample_decimator_capture #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .decim      (decim),
        .avg_en     (avg_en),
        .avg_shift  (avg_shift),
        .num_frames (num_frames),
        .arm        (arm),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_cfg(input logic [15:0] d, input logic a,
                           input logic [4:0] s, input logic [15:0] nf);
        @(posedge clk); #1;
        decim = d; avg_en = a; avg_shift = s; num_frames = nf; arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic drive_ctr(input int n, input logic [7:0] c1);
        for (int k = 0; k < n; k++) begin
            bus.in_data  = {c1, 8'(k)};
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_const(input int n, input logic [15:0] d);
        for (int k = 0; k < n; k++) begin
            bus.in_data  = d;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0;
        decim = 16'd1; avg_en = 1'b0; avg_shift = 5'd0; num_frames = 16'd0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        avg_c0[0] = 8'd10; avg_c0[1] = 8'd20;
        avg_c0[2] = 8'd30; avg_c0[3] = 8'd41;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // point mode, decim 272 on a byte counter
        bus.out_ready = 1'b1;
        base = got.size();
        arm_cfg(16'd272, 1'b0, 5'd0, 16'd4);
        drive_ctr(1088, 8'h5A);
        wait_done("t1_done", 100);
        chk("t1_count", 32'(got.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < got.size(); i++)
            chk($sformatf("t1_f%0d", i), 32'(got[base+i]),
                32'({8'h5A, 8'(16 * i)}));
        chk("t1_busy", 32'(busy), 32'd0);

        // boxcar: shift 2, then saturating shift 0, then uneven samples
        base = got.size();
        arm_cfg(16'd4, 1'b1, 5'd2, 16'd3);
        drive_const(12, 16'hFFC8);
        wait_done("t2a_done", 100);
        chk("t2a_count", 32'(got.size() - base), 32'd3);
        for (int i = 0; i < 3 && base + i < got.size(); i++)
            chk($sformatf("t2a_f%0d", i), 32'(got[base+i]), 32'hFFC8);
        base = got.size();
        arm_cfg(16'd4, 1'b1, 5'd0, 16'd1);
        drive_const(4, 16'hFFC8);
        wait_done("t2b_done", 100);
        chk("t2b_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) chk("t2b_sat", 32'(got[base]), 32'hFFFF);
        base = got.size();
        arm_cfg(16'd4, 1'b1, 5'd2, 16'd1);
        for (int k = 0; k < 4; k++) begin
            bus.in_data  = {((k == 3) ? 8'd4 : 8'd0), avg_c0[k]};
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_done("t2c_done", 100);
        if (got.size() > base) chk("t2c_avg", 32'(got[base]), 32'h0119);

        // decim 1, consumer stalled: 16 kept, 4 dropped
        bus.out_ready = 1'b0;
        arm_cfg(16'd1, 1'b0, 5'd0, 16'd20);
        drive_ctr(20, 8'h77);
        repeat (3) @(negedge clk);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_head", 32'(bus.out_data), 32'h7700);
        @(posedge clk); #1;
        base = got.size();
        bus.out_ready = 1'b1;
        wait_done("t3_done", 100);
        chk("t3_count", 32'(got.size() - base), 32'd16);
        if (got.size() >= base + 16) begin
            chk("t3_first", 32'(got[base]), 32'h7700);
            chk("t3_last", 32'(got[base+15]), 32'h770F);
        end

        // decim 0 acts as 1; out_valid two cycles after first strobe
        bus.out_ready = 1'b0;
        arm_cfg(16'd0, 1'b0, 5'd0, 16'd3);
        bus.in_data = 16'h4C00; bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t4_lat0", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_data = 16'h4C01;
        @(negedge clk);
        chk("t4_lat1", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_data = 16'h4C02;
        @(negedge clk);
        chk("t4_lat2", 32'(bus.out_valid), 32'd1);
        chk("t4_head", 32'(bus.out_data), 32'h4C00);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        base = got.size();
        bus.out_ready = 1'b1;
        wait_done("t4_done", 100);
        chk("t4_count", 32'(got.size() - base), 32'd3);
        for (int i = 0; i < 3 && base + i < got.size(); i++)
            chk($sformatf("t4_f%0d", i), 32'(got[base+i]), 32'h4C00 + i);

        // continuous, stop at 3.5 windows; arm in RUN ignored
        base = got.size();
        arm_cfg(16'd8, 1'b0, 5'd0, 16'd0);
        for (int k = 0; k < 28; k++) begin
            bus.in_data  = {8'hC5, 8'(k)};
            bus.in_valid = 1'b1;
            arm = (k == 12);
            @(posedge clk); #1;
        end
        arm = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        bus.in_data = 16'hC51C; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; bus.in_valid = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_count", 32'(got.size() - base), 32'd3);
        for (int i = 0; i < 3 && base + i < got.size(); i++)
            chk($sformatf("t5_f%0d", i), 32'(got[base+i]),
                32'({8'hC5, 8'(8 * i)}));

        // reset mid-capture, then re-arm
        bus.out_ready = 1'b0;
        arm_cfg(16'd1, 1'b0, 5'd0, 16'd0);
        drive_ctr(20, 8'h11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_ovf_pre", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_data", 32'(bus.out_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = got.size();
        arm_cfg(16'd2, 1'b0, 5'd0, 16'd2);
        drive_ctr(4, 8'h22);
        wait_done("t6_done", 100);
        chk("t6_count", 32'(got.size() - base), 32'd2);
        if (got.size() >= base + 2) begin
            chk("t6_f0", 32'(got[base]), 32'h2200);
            chk("t6_f1", 32'(got[base+1]), 32'h2202);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
